// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one UART transmitter.
// Define UART_ARB_TIMEOUT_EN to add a watchdog on the uart_busy handshake.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       uart_start,
    output logic [7:0]                 uart_data,
    input  logic                       uart_busy,
    output logic [$clog2(NUM_REQ)-1:0] active_id,
    output logic                       arb_busy,
    output logic                       err
);

    localparam int          ID_W   = $clog2(NUM_REQ);
    localparam int unsigned NREQ_U = NUM_REQ;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               uart_start_q, uart_start_d;
    logic [7:0]         uart_data_q, uart_data_d;
    logic [ID_W-1:0]    active_id_q, active_id_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic               arb_busy_q, arb_busy_d;

    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic [7:0]         win_data;
    int unsigned        idx;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
`endif

    // Search upward from the slot after the last grant, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int unsigned k = 1; k <= NREQ_U; k++) begin
            idx = (32'(last_grant_q) + k) % NREQ_U;
            if (!win_found && req[idx[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            if (win_id == ID_W'(i)) begin
                win_data = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = '0;
        uart_start_d = 1'b0;
        uart_data_d  = uart_data_q;
        active_id_d  = active_id_q;
        last_grant_d = last_grant_q;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // A busy UART in IDLE is owned elsewhere; hold off until it frees.
                if (win_found && !uart_busy) begin
                    gnt_d[win_id] = 1'b1;
                    uart_start_d  = 1'b1;
                    uart_data_d   = win_data;
                    active_id_d   = win_id;
                    last_grant_d  = win_id;
                    state_d       = S_WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d         = '0;
`endif
                end
            end
            S_WAIT_BUSY: begin
                if (uart_busy) begin
                    state_d = S_WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            S_WAIT_DONE: begin
                if (!uart_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        arb_busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            gnt_q        <= '0;
            uart_start_q <= 1'b0;
            uart_data_q  <= 8'h00;
            active_id_q  <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            arb_busy_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            uart_start_q <= uart_start_d;
            uart_data_q  <= uart_data_d;
            active_id_q  <= active_id_d;
            last_grant_q <= last_grant_d;
            arb_busy_q   <= arb_busy_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign gnt        = gnt_q;
    assign uart_start = uart_start_q;
    assign uart_data  = uart_data_q;
    assign active_id  = active_id_q;
    assign arb_busy   = arb_busy_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of requesters sharing one uart transmitter (legal range 2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 8, meaning the maximum number of cycles to wait for uart_busy to rise after a start pulse.
REQ-003 SHALL have port clk, input, width 1, meaning the system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, width 1, meaning the reset, which is synchronous and active-high.
REQ-005 SHALL have port req, input, width NUM_REQ, meaning per-requester byte-send request, held until its gnt bit pulses.
REQ-006 SHALL have port req_data, input, width 8*NUM_REQ, meaning packed bytes, with requester i at bits [8i+7:8i].
REQ-007 SHALL have port gnt, output, width NUM_REQ, meaning a one-cycle pulse when requester i's byte is captured.
REQ-008 SHALL have port uart_start, output, width 1, meaning the one-cycle start strobe to the uart start_tx input.
REQ-009 SHALL have port uart_data, output, width 8, meaning the byte to the uart data input, stable from the start pulse until the transfer ends.
REQ-010 SHALL have port uart_busy, input, width 1, meaning the uart busy flag.
REQ-011 SHALL have port active_id, output, width $clog2(NUM_REQ), meaning the index of the requester currently owning the uart.
REQ-012 SHALL have port arb_busy, output, width 1, meaning high whenever the FSM is not in IDLE.
REQ-013 SHALL have port err, output, width 1, meaning a one-cycle timeout pulse; it is tied to 0 when the timeout feature is compiled out.

Function
REQ-014 SHALL implement the FSM states IDLE, WAIT_BUSY and WAIT_DONE; all outputs SHALL be registered.
REQ-015 SHALL, in IDLE with req != 0, select the winner round-robin, searching upward from (last_grant+1) mod NUM_REQ with wraparound.
REQ-016 SHALL, on the next edge after winner selection, assert gnt[winner] for exactly one cycle.
REQ-017 SHALL, on that same edge, assert uart_start for exactly one cycle, load uart_data with the winner's byte, set active_id and last_grant to the winner, and enter WAIT_BUSY.
REQ-018 SHALL stay in WAIT_BUSY until uart_busy=1 is sampled, then enter WAIT_DONE.
REQ-019 SHALL stay in WAIT_DONE until uart_busy=0 is sampled, then enter IDLE.
REQ-020 SHALL give a minimum IDLE-to-IDLE dwell of one cycle, so the next grant occurs no earlier than one cycle after returning to IDLE.
REQ-021 SHALL ignore req changes outside IDLE; the bytes of requesters that are not granted are never sampled.
REQ-022 SHALL, when a sole requester holds req continuously, grant it back to back, once per transfer.
REQ-023 SHALL grant at most one gnt bit per cycle; gnt SHALL be 0 outside the grant cycle.
REQ-024 SHALL leave uart_data and active_id holding their last values while in IDLE.
REQ-025 SHALL treat uart_busy already high in IDLE as "resource occupied" and issue no grant until it falls.

Reset
REQ-026 SHALL, with rst high at a clock edge, force state=IDLE, gnt=0, uart_start=0, uart_data=8'h00, active_id=0, arb_busy=0, err=0 and last_grant=NUM_REQ-1, so that requester 0 has first priority.
REQ-027 SHALL abort any in-progress transfer on reset mid-operation, with no gnt or uart_start emitted in the reset cycle.

Configuration
REQ-028 SHALL, with macro UART_ARB_TIMEOUT_EN defined, count cycles in WAIT_BUSY; if uart_busy has not risen after TIMEOUT_CYCLES cycles, it SHALL pulse err for one cycle, return to IDLE and keep last_grant advanced.
REQ-029 SHALL, with UART_ARB_TIMEOUT_EN undefined, have no timeout counter, make WAIT_BUSY wait indefinitely and tie err constant 0.

Verification
REQ-030 SHALL cover: reset, then req=4'b0001 with byte 8'hA5 -> gnt=4'b0001 for one cycle with uart_start=1 and uart_data=8'hA5; arb_busy falls one cycle after uart_busy falls.
REQ-031 SHALL cover: req=4'b1111 held through four transfers -> grant order 0,1,2,3, then 0 again.
REQ-032 SHALL cover: last_grant=2 and req=4'b0011 -> requester 0 granted (wraparound), followed by requester 1.
REQ-033 SHALL cover: uart_busy forced high in IDLE while req=4'b0010 -> no gnt until uart_busy falls, then gnt=4'b0010.
REQ-034 SHALL cover: rst asserted during WAIT_DONE -> all outputs at reset values next cycle; after release with req=4'b1000, requester 3 is granted and the pointer restarts from 0.
REQ-035 SHALL cover, with UART_ARB_TIMEOUT_EN defined: uart_busy held 0 after start -> err pulses exactly once, TIMEOUT_CYCLES=8 cycles after WAIT_BUSY entry, and the FSM returns to IDLE.
